// File: rtl/emu_clock_reset_ctrl_pkg.sv
// Shared types and constants for the emu clock-enable / core-reset sequencer.
// Optional feature macro: IOCTL_THROTTLE_EN (ioctl write throttling in the top).
package emu_clk_pkg;

    // Core reset sequencer states.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        ALIGN   = 2'd2,
        RUN     = 2'd3
    } state_t;

    // ioctl_index value that marks a ROM download unless overridden.
    localparam logic [7:0] DEF_ROM_INDEX = 8'd0;

    // Width of the ioctl download index bus.
    localparam int IOCTL_IDX_W = 8;

    // Period in clocks of clock-enable channel k for a given base shift.
    function automatic int unsigned ce_period(input int unsigned base_shift,
                                              input int unsigned k);
        return 32'd1 << (base_shift + k);
    endfunction

endpackage

// File: rtl/emu_clock_reset_ctrl_if.sv
// ioctl download bus between the host (master) and the reset sequencer (slave).
// ioctl_wait is only driven active when IOCTL_THROTTLE_EN is defined.
interface emu_clock_reset_ctrl_if;
    import emu_clk_pkg::*;

    logic                   ioctl_download;
    logic [IOCTL_IDX_W-1:0] ioctl_index;
    logic                   ioctl_wr;
    logic                   ioctl_wait;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        output ioctl_wait
    );

endinterface

// File: rtl/emu_clock_reset_ctrl_ce_divider.sv
// Free-running divider producing power-of-two clock enables and matching
// pre-enables that fire exactly one clock ahead of each enable.
module emu_ce_divider #(
    parameter int NUM_CE     = 3,
    parameter int BASE_SHIFT = 2
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    output logic [NUM_CE-1:0] ce_o,
    output logic [NUM_CE-1:0] ce_pre_o
);

    // The slowest channel spans the whole counter, so it wraps on its own period.
    localparam int DIV_W = BASE_SHIFT + NUM_CE - 1;

    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic [DIV_W-1:0]  div_p1;
    logic [DIV_W-1:0]  div_p2;
    logic [NUM_CE-1:0] ce_q;
    logic [NUM_CE-1:0] ce_d;
    logic [NUM_CE-1:0] ce_pre_q;
    logic [NUM_CE-1:0] ce_pre_d;

    assign div_p1 = div_q + DIV_W'(1);
    assign div_p2 = div_q + DIV_W'(2);
    assign div_d  = div_p1;

    // Channel k fires when the low BASE_SHIFT+k bits of the look-ahead count are zero.
    for (genvar k = 0; k < NUM_CE; k++) begin : g_ce
        localparam logic [DIV_W:0]   SPAN = (DIV_W + 1)'(1) << (BASE_SHIFT + k);
        localparam logic [DIV_W-1:0] MASK = DIV_W'(SPAN - (DIV_W + 1)'(1));
        assign ce_d[k]     = ((div_p1 & MASK) == '0);
        assign ce_pre_d[k] = ((div_p2 & MASK) == '0);
    end

    // Counter and registered enables; all cleared while reset_n is low.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            div_q    <= '0;
            ce_q     <= '0;
            ce_pre_q <= '0;
        end else begin
            div_q    <= div_d;
            ce_q     <= ce_d;
            ce_pre_q <= ce_pre_d;
        end
    end

    assign ce_o     = ce_q;
    assign ce_pre_o = ce_pre_q;

endmodule

// File: rtl/emu_clock_reset_ctrl.sv
// Clock-enable generator and core-reset sequencer for the emu top level.
// Core reset is stretched after host reset / ROM download and released on a
// slowest-channel phase boundary. Define IOCTL_THROTTLE_EN to enable ioctl_wait.
module emu_clock_reset_ctrl
    import emu_clk_pkg::*;
#(
    parameter int         NUM_CE      = 3,
    parameter int         BASE_SHIFT  = 2,
    parameter logic [7:0] ROM_INDEX   = DEF_ROM_INDEX,
    parameter int         HOLD_CYCLES = 16,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   host_reset,
    emu_clock_reset_ctrl_if.slave  ioctl,
    output logic [NUM_CE-1:0]      ce,
    output logic [NUM_CE-1:0]      ce_pre,
    output logic                   core_reset
);

    localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             core_reset_q;
    logic             core_reset_d;
    logic             req;

    emu_ce_divider #(
        .NUM_CE     (NUM_CE),
        .BASE_SHIFT (BASE_SHIFT)
    ) u_divider (
        .clk_i      (clk_sys),
        .reset_n_i  (reset_n),
        .ce_o       (ce),
        .ce_pre_o   (ce_pre)
    );

    // Only ROM downloads hold the core in reset; other indices pass through.
    assign req = host_reset | (ioctl.ioctl_download & (ioctl.ioctl_index == ROM_INDEX));

    // Next state: stretch after the request drops, then wait for the slow phase.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        core_reset_d = 1'b1;
        unique case (state_q)
            HOLD: begin
                cnt_d = '0;
                if (!req) begin
                    state_d = STRETCH;
                end
            end
            STRETCH: begin
                if (req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = ALIGN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ALIGN: begin
                if (req) begin
                    state_d = HOLD;
                end else if (ce_pre[NUM_CE-1]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (req) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
        core_reset_d = (state_d != RUN);
    end

    // State, stretch counter and registered core reset.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign core_reset = core_reset_q;

`ifdef IOCTL_THROTTLE_EN
    localparam int WCNT_W = $clog2(WAIT_CYCLES + 1);

    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic              wait_q;

    // Each write (re)loads the wait window; dropping download cancels it.
    always_comb begin
        wcnt_d = wcnt_q;
        if (!ioctl.ioctl_download) begin
            wcnt_d = '0;
        end else if (ioctl.ioctl_wr) begin
            wcnt_d = WCNT_W'(WAIT_CYCLES);
        end else if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - WCNT_W'(1);
        end
    end

    // Wait is registered so it rises the cycle after the write strobe.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wcnt_q <= '0;
            wait_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            wait_q <= (wcnt_d != '0);
        end
    end

    assign ioctl.ioctl_wait = wait_q;
`else
    logic unused_throttle;
    assign unused_throttle  = ^{ioctl.ioctl_wr, 32'(WAIT_CYCLES)};
    assign ioctl.ioctl_wait = 1'b0;
`endif

endmodule

// File: tb/tb_emu_clock_reset_ctrl.sv
// Directed bench for emu_clock_reset_ctrl with default parameters.
// Expectations for ioctl_wait follow IOCTL_THROTTLE_EN when it is defined.
module tb_emu_clock_reset_ctrl;
    import emu_clk_pkg::*;

`ifdef IOCTL_THROTTLE_EN
    localparam bit THROTTLE = 1'b1;
`else
    localparam bit THROTTLE = 1'b0;
`endif

    typedef struct {
        logic       hostReset;
        logic       download;
        logic [7:0] index;
        logic       wr;
        logic [2:0] expCe;
        logic [2:0] expCePre;
        logic       expCoreReset;
    } vec_t;

    logic       clkSys;
    logic       resetN;
    logic       hostReset;
    logic [2:0] ce;
    logic [2:0] cePre;
    logic       coreReset;

    int checks;
    int errors;
    int cyc;

    vec_t vecs[17];

    emu_clock_reset_ctrl_if ioctlIf ();

    emu_clock_reset_ctrl dut (
        .clk_sys    (clkSys),
        .reset_n    (resetN),
        .host_reset (hostReset),
        .ioctl      (ioctlIf),
        .ce         (ce),
        .ce_pre     (cePre),
        .core_reset (coreReset)
    );

    // Free-running system clock.
    initial clkSys = 1'b0;
    always #5 clkSys = ~clkSys;

    // Compare one value and log any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Advance one clock edge and settle on the falling edge for sampling.
    task automatic step();
        @(posedge clkSys);
        cyc++;
        @(negedge clkSys);
    endtask

    // Drive the request inputs, then take one clock.
    task automatic applyStimulus(input logic hr, input logic dl,
                                 input logic [7:0] idx, input logic wr);
        hostReset              = hr;
        ioctlIf.ioctl_download = dl;
        ioctlIf.ioctl_index    = idx;
        ioctlIf.ioctl_wr       = wr;
        step();
    endtask

    // Enable pattern expected n clocks after reset_n release.
    function automatic logic [2:0] modelCe(input int n);
        logic [2:0] r;
        for (int k = 0; k < 3; k++) begin
            r[k] = (n > 0) && ((n % int'(ce_period(2, k))) == 0);
        end
        return r;
    endfunction

    // Cycle core_reset falls when the last request was sampled at edge h.
    function automatic int expRelease(input int h);
        return ((h + 18 + 15) / 16) * 16;
    endfunction

    // Step until core_reset falls (bounded), then check timing and phase.
    task automatic waitRelease(input int lastReq, input string name);
        int guard;
        guard = 0;
        while (coreReset === 1'b1 && guard < 300) begin
            step();
            guard++;
        end
        checkOutput({name, "_cycle"}, 32'(cyc), 32'(expRelease(lastReq)));
        checkOutput({name, "_ceSlow"}, 32'(ce[2]), 32'd1);
        checkOutput({name, "_stretch"}, 32'((cyc - lastReq) >= 16), 32'd1);
    endtask

    // Expected ioctl_wait given what the throttle would produce.
    function automatic logic expWait(input logic v);
        return THROTTLE ? v : 1'b0;
    endfunction

    initial begin
        int h;
        int h2;
        checks = 0;
        errors = 0;
        cyc    = 0;

        vecs[0]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b001, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b001, 3'b000, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b011, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b011, 3'b000, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b001, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b001, 3'b000, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b111, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b111, 3'b000, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 3'b000, 1'b1};

        resetN                 = 1'b0;
        hostReset              = 1'b0;
        ioctlIf.ioctl_download = 1'b0;
        ioctlIf.ioctl_index    = 8'd0;
        ioctlIf.ioctl_wr       = 1'b0;

        // Reset held: no enables, core in reset, no wait.
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rst_ce", 32'(ce), 32'd0);
            checkOutput("rst_cePre", 32'(cePre), 32'd0);
            checkOutput("rst_coreReset", 32'(coreReset), 32'd1);
            checkOutput("rst_wait", 32'(ioctlIf.ioctl_wait), 32'd0);
        end

        // Test 1: enable phasing after release, table driven.
        resetN = 1'b1;
        cyc    = 0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].hostReset, vecs[i].download, vecs[i].index, vecs[i].wr);
            checkOutput("tbl_ce", 32'(ce), 32'(vecs[i].expCe));
            checkOutput("tbl_cePre", 32'(cePre), 32'(vecs[i].expCePre));
            checkOutput("tbl_coreReset", 32'(coreReset), 32'(vecs[i].expCoreReset));
        end
        while (cyc < 31) begin
            step();
            checkOutput("run1_ce", 32'(ce), 32'(modelCe(cyc)));
            checkOutput("run1_cePre", 32'(cePre), 32'(modelCe(cyc + 1)));
            checkOutput("run1_coreReset", 32'(coreReset), 32'd1);
        end
        waitRelease(0, "powerOn");
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput("run_ce", 32'(ce), 32'(modelCe(cyc)));
            checkOutput("run_cePre", 32'(cePre), 32'(modelCe(cyc + 1)));
            checkOutput("run_coreReset", 32'(coreReset), 32'd0);
        end

        // Test 2: single-cycle host reset pulse in RUN.
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        h = cyc;
        checkOutput("hostPulse_coreReset", 32'(coreReset), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        waitRelease(h, "hostPulse");

        // Test 3a: ROM download holds core reset throughout.
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0);
        checkOutput("rom_coreReset", 32'(coreReset), 32'd1);
        for (int i = 1; i < 100; i++) begin
            step();
            checkOutput("rom_hold", 32'(coreReset), 32'd1);
        end
        h = cyc;
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        waitRelease(h, "romDone");

        // Test 3b: download to another index never resets the core.
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0);
        checkOutput("otherIdx_coreReset", 32'(coreReset), 32'd0);
        for (int i = 1; i < 100; i++) begin
            step();
            checkOutput("otherIdx_run", 32'(coreReset), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        checkOutput("otherIdx_after", 32'(coreReset), 32'd0);

        // Test 4: host reset re-asserted while stretching at count 10.
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        h = cyc;
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        while (cyc < h + 11) begin
            step();
        end
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        h2 = cyc;
        checkOutput("restretch_coreReset", 32'(coreReset), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        waitRelease(h2, "restretch");

        // Test 5: write throttle on a non-ROM download.
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b1);
        checkOutput("wr1_wait0", 32'(ioctlIf.ioctl_wait), 32'(expWait(1'b1)));
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b0);
        checkOutput("wr1_wait1", 32'(ioctlIf.ioctl_wait), 32'(expWait(1'b1)));
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b0);
        checkOutput("wr1_wait2", 32'(ioctlIf.ioctl_wait), 32'(expWait(1'b0)));
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b0);
        checkOutput("wr1_wait3", 32'(ioctlIf.ioctl_wait), 32'(expWait(1'b0)));
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b1);
        checkOutput("wr2_wait0", 32'(ioctlIf.ioctl_wait), 32'(expWait(1'b1)));
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b1);
        checkOutput("wr2_wait1", 32'(ioctlIf.ioctl_wait), 32'(expWait(1'b1)));
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b0);
        checkOutput("wr2_wait2", 32'(ioctlIf.ioctl_wait), 32'(expWait(1'b1)));
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b0);
        checkOutput("wr2_wait3", 32'(ioctlIf.ioctl_wait), 32'(expWait(1'b0)));
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b1);
        checkOutput("wr3_wait0", 32'(ioctlIf.ioctl_wait), 32'(expWait(1'b1)));
        applyStimulus(1'b0, 1'b0, 8'd5, 1'b0);
        checkOutput("wr3_dropWait", 32'(ioctlIf.ioctl_wait), 32'd0);
        checkOutput("wr_coreReset", 32'(coreReset), 32'd0);

        // Test 6: reset_n asserted while waiting for phase alignment.
        while ((cyc % 16) != 0) begin
            step();
        end
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        h = cyc;
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        while (cyc < h + 18) begin
            step();
        end
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b1);
        checkOutput("align_coreReset", 32'(coreReset), 32'd1);
        checkOutput("align_wait", 32'(ioctlIf.ioctl_wait), 32'(expWait(1'b1)));
        resetN = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'd5, 1'b1);
        checkOutput("midRst_ce", 32'(ce), 32'd0);
        checkOutput("midRst_cePre", 32'(cePre), 32'd0);
        checkOutput("midRst_coreReset", 32'(coreReset), 32'd1);
        checkOutput("midRst_wait", 32'(ioctlIf.ioctl_wait), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        resetN = 1'b1;
        cyc    = 0;
        for (int i = 0; i < 17; i++) begin
            step();
            checkOutput("restart_ce", 32'(ce), 32'(modelCe(cyc)));
            checkOutput("restart_cePre", 32'(cePre), 32'(modelCe(cyc + 1)));
        end
        waitRelease(0, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
